if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipeline. It holds the architectural fetch PC, drives the instruction ROM address, and presents the PC to the next-PC logic. Each cycle it loads the next-PC result. It also owns the IF/ID pipeline register, which it stalls on a load-use hazard and flushes into a bubble on a redirect. Fetch and bubble counters feed the trace and debug interface.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; must be word-aligned.
- NOP_INST, 32'h0000_0013: instruction word inserted for a bubble (addi x0,x0,0).

- cpu_clk  in  1  clock; all state updates on the rising edge.
- cpu_rst_n  in  1  reset: asynchronous, active-low.
- npc  in  32  next PC from the next-PC logic.
- pipeline_stop  in  1  load-use stall from the hazard unit.
- control_hazard_update_pc  in  1  redirect/flush from the hazard unit (branch taken, jump, or indirect).
- irom_inst  in  32  instruction word; combinational function of irom_adr.
- pc  out  32  current fetch PC, to the next-PC logic and the trace.
- irom_adr  out  14  pc[15:2], word address to the instruction ROM.
- id_pc  out  32  IF/ID register: PC of the instruction in ID.
- id_pc4  out  32  IF/ID register: id_pc + 4.
- id_inst  out  32  IF/ID register: instruction word.
- id_valid  out  1  IF/ID register holds a real instruction.
- fetch_cnt  out  32  number of instructions passed into ID.
- bubble_cnt  out  32  number of flush bubbles inserted.

## Operation
- State machine with two states.
  - BOOT: entered on reset.
  - RUN: the normal fetch state.
- In BOOT, the first rising edge after cpu_rst_n deasserts moves the block to RUN.
  - That edge leaves pc, the IF/ID register and both counters unchanged.
  - npc and all hazard inputs are ignored in BOOT.
- In RUN, each rising edge applies the first matching case below, highest priority first.
  - Flush (control_hazard_update_pc=1): pc <= {npc[31:2],2'b00}. The IF/ID register loads a bubble. bubble_cnt += 1. The flush wins over pipeline_stop.
  - Stall (pipeline_stop=1): pc holds and the IF/ID register holds; npc is ignored. No counter changes.
  - Normal: pc <= {npc[31:2],2'b00}. The IF/ID register loads {id_pc=pc, id_pc4=pc+4, id_inst=irom_inst, id_valid=1}. fetch_cnt += 1.
- Bubble contents: id_pc=0, id_pc4=0, id_inst=NOP_INST, id_valid=0.
- Arithmetic and width rules:
  - pc+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - Both counters are 32-bit and wrap from 32'hFFFF_FFFF to 0.
  - npc[1:0] is always discarded.
- irom_adr = pc[15:2], combinational from the pc register. pc[31:16] is not decoded.
- Reset (asynchronous, at any time, including mid-stall or mid-flush) forces the following immediately, without waiting for a clock:
  - state BOOT
  - pc = RESET_PC
  - IF/ID register = bubble
  - fetch_cnt = 0, bubble_cnt = 0

## Timing
- Reset values of every output:
  - pc = RESET_PC
  - irom_adr = RESET_PC[15:2]
  - id_pc = 0, id_pc4 = 0
  - id_inst = NOP_INST
  - id_valid = 0
  - fetch_cnt = 0, bubble_cnt = 0
- Latency from a fetch to ID:
  - The word at pc appears on id_inst one edge later, when the cycle is neither stalled nor flushed.
  - The first instruction (at RESET_PC) reaches ID on the second rising edge after reset release: the first edge is consumed by BOOT.
- Redirect:
  - On the flush edge, pc takes the target.
  - The wrong-path instruction fetched in that cycle is dropped; ID shows a bubble for exactly one cycle.
  - The target instruction reaches ID on the next edge, if that edge is not stalled.
- Stall:
  - A stall of N cycles freezes pc and the IF/ID register for N edges.
  - The ID outputs stay stable throughout, and the instruction is not re-counted.
- All outputs are registered except irom_adr, which is pure wiring from pc. There are no combinational paths from inputs to outputs.

## Test plan
- Reset and boot: assert cpu_rst_n=0 mid-cycle.
  - Expect pc=0, id_valid=0, id_inst=32'h13 immediately.
  - After release, edge 1 leaves pc=0. Edge 2 (npc=4) gives pc=4, id_pc=0, id_pc4=4, id_valid=1, fetch_cnt=1.
- Sequential fetch: drive npc=pc+4 for 5 edges in RUN from pc=0x10.
  - Expect id_pc steps 0x10, 0x14, ... 0x20, pc=0x24, fetch_cnt increases by 5.
- Stall: from pc=0x40 with id_pc=0x3C, hold pipeline_stop=1 for 3 edges with npc=0x44.
  - Expect pc=0x40, id_pc=0x3C and fetch_cnt unchanged.
  - On release, the next edge gives id_pc=0x40.
- Flush beats stall: with control_hazard_update_pc=1, pipeline_stop=1 and npc=0x103 at pc=0x50.
  - Expect pc=0x100, id_valid=0, id_inst=32'h13, bubble_cnt +1, fetch_cnt unchanged.
  - The next normal edge gives id_pc=0x100.
- Wrap-around: preload pc=32'hFFFF_FFFC and fetch_cnt=32'hFFFF_FFFF (via RESET_PC and forced counter), then run one normal edge with npc=0.
  - Expect id_pc4=0, pc=0, fetch_cnt=0.
- Reset mid-operation: assert reset while stalled with id_valid=1 and bubble_cnt=7.
  - Expect all outputs back to their reset values without a clock, then the BOOT sequence repeats.

Source files
------------

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: next-PC logic,
// hazard unit, instruction ROM, ID stage and trace/debug.
interface if_stage_if;
   logic [31:0] npc;
   logic        pipeline_stop;
   logic        control_hazard_update_pc;
   logic [31:0] irom_inst;
   logic [31:0] pc;
   logic [13:0] irom_adr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [31:0] id_inst;
   logic        id_valid;
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;

   modport master (
      input  npc,
      input  pipeline_stop,
      input  control_hazard_update_pc,
      input  irom_inst,
      output pc,
      output irom_adr,
      output id_pc,
      output id_pc4,
      output id_inst,
      output id_valid,
      output fetch_cnt,
      output bubble_cnt
   );

   modport slave (
      output npc,
      output pipeline_stop,
      output control_hazard_update_pc,
      output irom_inst,
      input  pc,
      input  irom_adr,
      input  id_pc,
      input  id_pc4,
      input  id_inst,
      input  id_valid,
      input  fetch_cnt,
      input  bubble_cnt
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC register, IF/ID pipeline register with
// load-use stall and redirect flush, plus fetch/bubble counters for trace.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic        cpu_clk,
   input logic        cpu_rst_n,
   if_stage_if.master bus
);

   typedef enum logic {BOOT, RUN} state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_pc4_q;
   logic [31:0] id_inst_q;
   logic        id_valid_q;
   logic [31:0] fetch_cnt_q;
   logic [31:0] bubble_cnt_q;

   logic [31:0] npc_aligned;
   logic [31:0] pc_plus4;

   assign npc_aligned = bus.npc & 32'hFFFF_FFFC;
   assign pc_plus4    = pc_q + 32'd4;

   // Redirect outranks stall so a taken branch is never lost behind a load-use bubble.
   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state        <= BOOT;
         pc_q         <= RESET_PC;
         id_pc_q      <= 32'h0;
         id_pc4_q     <= 32'h0;
         id_inst_q    <= NOP_INST;
         id_valid_q   <= 1'b0;
         fetch_cnt_q  <= 32'h0;
         bubble_cnt_q <= 32'h0;
      end else begin
         case (state)
            BOOT: begin
               state <= RUN;
            end
            RUN: begin
               if (bus.control_hazard_update_pc) begin
                  pc_q         <= npc_aligned;
                  id_pc_q      <= 32'h0;
                  id_pc4_q     <= 32'h0;
                  id_inst_q    <= NOP_INST;
                  id_valid_q   <= 1'b0;
                  bubble_cnt_q <= bubble_cnt_q + 32'd1;
               end else if (!bus.pipeline_stop) begin
                  pc_q        <= npc_aligned;
                  id_pc_q     <= pc_q;
                  id_pc4_q    <= pc_plus4;
                  id_inst_q   <= bus.irom_inst;
                  id_valid_q  <= 1'b1;
                  fetch_cnt_q <= fetch_cnt_q + 32'd1;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   assign bus.pc         = pc_q;
   assign bus.irom_adr   = pc_q[15:2];
   assign bus.id_pc      = id_pc_q;
   assign bus.id_pc4     = id_pc4_q;
   assign bus.id_inst    = id_inst_q;
   assign bus.id_valid   = id_valid_q;
   assign bus.fetch_cnt  = fetch_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected post-edge state,
// a monitor pops and compares after every rising edge.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic cpu_clk;
   logic cpu_rst_n;
   logic rst_w_n;

   if_stage_if bus ();
   if_stage_if bus_w ();

   if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst_n (cpu_rst_n),
      .bus       (bus)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_w (
      .cpu_clk   (cpu_clk),
      .cpu_rst_n (rst_w_n),
      .bus       (bus_w)
   );

   function automatic logic [31:0] irom_fn(input logic [13:0] a);
      return {a, 4'h5, a} ^ 32'h1234_5678;
   endfunction

   assign bus.irom_inst   = irom_fn(bus.irom_adr);
   assign bus_w.irom_inst = irom_fn(bus_w.irom_adr);

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] id_pc;
      logic [31:0] id_pc4;
      logic [31:0] id_inst;
      logic        id_valid;
      logic [31:0] fetch_cnt;
      logic [31:0] bubble_cnt;
   } exp_t;

   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   logic        m_boot;
   logic [31:0] m_pc;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_pc4;
   logic [31:0] m_id_inst;
   logic        m_id_valid;
   logic [31:0] m_fetch;
   logic [31:0] m_bubble;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_boot     = 1'b1;
      m_pc       = 32'h0;
      m_id_pc    = 32'h0;
      m_id_pc4   = 32'h0;
      m_id_inst  = NOP;
      m_id_valid = 1'b0;
      m_fetch    = 32'h0;
      m_bubble   = 32'h0;
   endtask

   // Called at a falling edge; drives inputs, queues the state expected after the next rising edge.
   task automatic applyStimulus(input logic [31:0] n, input logic stop, input logic flush);
      exp_t e;
      bus.npc                      = n;
      bus.pipeline_stop            = stop;
      bus.control_hazard_update_pc = flush;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (flush) begin
         m_pc       = {n[31:2], 2'b00};
         m_id_pc    = 32'h0;
         m_id_pc4   = 32'h0;
         m_id_inst  = NOP;
         m_id_valid = 1'b0;
         m_bubble   = m_bubble + 32'd1;
      end else if (!stop) begin
         m_id_pc    = m_pc;
         m_id_pc4   = m_pc + 32'd4;
         m_id_inst  = irom_fn(m_pc[15:2]);
         m_id_valid = 1'b1;
         m_pc       = {n[31:2], 2'b00};
         m_fetch    = m_fetch + 32'd1;
      end
      e.pc         = m_pc;
      e.id_pc      = m_id_pc;
      e.id_pc4     = m_id_pc4;
      e.id_inst    = m_id_inst;
      e.id_valid   = m_id_valid;
      e.fetch_cnt  = m_fetch;
      e.bubble_cnt = m_bubble;
      sb_q.push_back(e);
      @(negedge cpu_clk);
   endtask

   always @(posedge cpu_clk) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checkOutput("sb_pc", bus.pc, e.pc);
         checkOutput("sb_irom_adr", {18'h0, bus.irom_adr}, {18'h0, e.pc[15:2]});
         checkOutput("sb_id_pc", bus.id_pc, e.id_pc);
         checkOutput("sb_id_pc4", bus.id_pc4, e.id_pc4);
         checkOutput("sb_id_inst", bus.id_inst, e.id_inst);
         checkOutput("sb_id_valid", {31'h0, bus.id_valid}, {31'h0, e.id_valid});
         checkOutput("sb_fetch_cnt", bus.fetch_cnt, e.fetch_cnt);
         checkOutput("sb_bubble_cnt", bus.bubble_cnt, e.bubble_cnt);
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_pc"}, bus.pc, 32'h0);
      checkOutput({tag, "_irom_adr"}, {18'h0, bus.irom_adr}, 32'h0);
      checkOutput({tag, "_id_pc"}, bus.id_pc, 32'h0);
      checkOutput({tag, "_id_pc4"}, bus.id_pc4, 32'h0);
      checkOutput({tag, "_id_inst"}, bus.id_inst, NOP);
      checkOutput({tag, "_id_valid"}, {31'h0, bus.id_valid}, 32'h0);
      checkOutput({tag, "_fetch_cnt"}, bus.fetch_cnt, 32'h0);
      checkOutput({tag, "_bubble_cnt"}, bus.bubble_cnt, 32'h0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      cpu_rst_n                      = 1'b1;
      rst_w_n                        = 1'b0;
      bus.npc                        = 32'h0;
      bus.pipeline_stop              = 1'b0;
      bus.control_hazard_update_pc   = 1'b0;
      bus_w.npc                      = 32'h0;
      bus_w.pipeline_stop            = 1'b0;
      bus_w.control_hazard_update_pc = 1'b0;
      modelReset();

      // Reset asserted mid-cycle takes effect without a clock edge.
      #2 cpu_rst_n = 1'b0;
      #1 checkResetValues("rst0");
      @(negedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
      $display("[TB] reset released, boot sequence");

      applyStimulus(32'h4, 1'b0, 1'b0);
      checkOutput("boot_pc_held", bus.pc, 32'h0);
      checkOutput("boot_fetch_cnt", bus.fetch_cnt, 32'h0);
      applyStimulus(32'h4, 1'b0, 1'b0);
      checkOutput("first_pc", bus.pc, 32'h4);
      checkOutput("first_id_pc", bus.id_pc, 32'h0);
      checkOutput("first_id_pc4", bus.id_pc4, 32'h4);
      checkOutput("first_id_valid", {31'h0, bus.id_valid}, 32'h1);
      checkOutput("first_fetch_cnt", bus.fetch_cnt, 32'h1);

      $display("[TB] sequential fetch");
      applyStimulus(32'h10, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(32'h14 + 32'(4 * i), 1'b0, 1'b0);
      checkOutput("seq_id_pc", bus.id_pc, 32'h20);
      checkOutput("seq_pc", bus.pc, 32'h24);
      checkOutput("seq_fetch_cnt", bus.fetch_cnt, 32'h7);

      $display("[TB] stall");
      applyStimulus(32'h3C, 1'b0, 1'b0);
      applyStimulus(32'h40, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h44, 1'b1, 1'b0);
         checkOutput("stall_pc", bus.pc, 32'h40);
         checkOutput("stall_id_pc", bus.id_pc, 32'h3C);
         checkOutput("stall_fetch_cnt", bus.fetch_cnt, 32'h9);
      end
      applyStimulus(32'h44, 1'b0, 1'b0);
      checkOutput("unstall_id_pc", bus.id_pc, 32'h40);

      $display("[TB] flush beats stall");
      applyStimulus(32'h50, 1'b0, 1'b0);
      applyStimulus(32'h103, 1'b1, 1'b1);
      checkOutput("flush_pc", bus.pc, 32'h100);
      checkOutput("flush_id_valid", {31'h0, bus.id_valid}, 32'h0);
      checkOutput("flush_id_inst", bus.id_inst, NOP);
      checkOutput("flush_bubble_cnt", bus.bubble_cnt, 32'h1);
      checkOutput("flush_fetch_cnt", bus.fetch_cnt, 32'hB);
      applyStimulus(32'h104, 1'b0, 1'b0);
      checkOutput("target_id_pc", bus.id_pc, 32'h100);
      applyStimulus(32'h10B, 1'b0, 1'b0);
      checkOutput("npc_low_bits", bus.pc, 32'h108);

      $display("[TB] reset mid-operation");
      for (int i = 0; i < 6; i++) applyStimulus(32'h200, 1'b0, 1'b1);
      applyStimulus(32'h204, 1'b0, 1'b0);
      applyStimulus(32'h300, 1'b1, 1'b0);
      checkOutput("pre_rst_bubble_cnt", bus.bubble_cnt, 32'h7);
      checkOutput("pre_rst_id_valid", {31'h0, bus.id_valid}, 32'h1);
      bus.pipeline_stop            = 1'b1;
      bus.control_hazard_update_pc = 1'b1;
      #2 cpu_rst_n = 1'b0;
      modelReset();
      #1 checkResetValues("rst1");
      @(negedge cpu_clk);
      checkResetValues("rst1_held");
      cpu_rst_n = 1'b1;
      applyStimulus(32'h8, 1'b0, 1'b0);
      checkOutput("reboot_pc_held", bus.pc, 32'h0);
      applyStimulus(32'h8, 1'b0, 1'b0);
      checkOutput("reboot_pc", bus.pc, 32'h8);
      checkOutput("reboot_fetch_cnt", bus.fetch_cnt, 32'h1);

      $display("[TB] wrap-around");
      rst_w_n = 1'b1;
      @(negedge cpu_clk);
      checkOutput("wrap_boot_pc", bus_w.pc, 32'hFFFF_FFFC);
      checkOutput("wrap_irom_adr", {18'h0, bus_w.irom_adr}, 32'h0000_3FFF);
      force dut_w.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut_w.fetch_cnt_q;
      @(negedge cpu_clk);
      checkOutput("wrap_id_pc", bus_w.id_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_id_pc4", bus_w.id_pc4, 32'h0);
      checkOutput("wrap_pc", bus_w.pc, 32'h0);
      checkOutput("wrap_fetch_cnt", bus_w.fetch_cnt, 32'h0);
      checkOutput("wrap_id_inst", bus_w.id_inst, irom_fn(14'h3FFF));

      if (sb_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
